// File: rtl/uart_frame_rx.sv
// uart_frame_rx - receive-side decoder for the "&&payload&&" UART string protocol.
//
// Consumes bytes from the uart_rx byte receiver, hunts for the "&&" opening
// delimiter and stores payload bytes in an internal buffer until the closing
// "&&". The result is reported with a one-cycle frame_done or frame_err pulse.
// A command parser then reads the payload through a registered read port.
//
// Optional build feature, selected by the macro UART_FRAME_RX_CHECKSUM_EN:
// the last payload byte is an XOR checksum of the bytes before it. It is
// stripped from frame_len. A mismatch, or an empty payload, aborts the frame
// with err_code 3.
//
// A lone '&' inside the payload is data. Because "&&" always closes the frame,
// an '&' is held back until the following byte shows what it means. It is
// written as data together with that byte. The byte after the '&' lands one
// cycle later through a one-entry pending register.

module uart_frame_rx #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int TIMEOUT_US = 1000,
    parameter int MAX_LEN    = 64,
    parameter int ADDR_W     = 6
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_vld,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              frame_done,
    output logic [7:0]        frame_len,
    output logic              frame_err,
    output logic [1:0]        err_code,
    output logic              busy
);

    // Last count value of the inter-byte gap timer
    localparam int TIMEOUT_CLK = CLK_FREQ / 1_000_000 * TIMEOUT_US - 1;
    localparam int TMO_W       = (TIMEOUT_CLK > 1) ? $clog2(TIMEOUT_CLK + 1) : 1;
    localparam logic [TMO_W-1:0] TMO_TC = TMO_W'(TIMEOUT_CLK);

    localparam logic [8:0] MAX_LEN_9 = 9'(MAX_LEN);
    localparam int         DEPTH     = 2 ** ADDR_W;
    localparam logic [7:0] AMP       = 8'h26;

    localparam logic [1:0] ERR_TIMEOUT  = 2'd1;
    localparam logic [1:0] ERR_OVERFLOW = 2'd2;
`ifdef UART_FRAME_RX_CHECKSUM_EN
    localparam logic [1:0] ERR_CHECKSUM = 2'd3;
`endif

    typedef enum logic [2:0] {
        S0_HUNT    = 3'd0,
        S1_START   = 3'd1,
        S2_PAYLOAD = 3'd2,
        S3_AMP     = 3'd3,
        S4_DONE    = 3'd4
    } state_t;

    state_t            state_r;
    state_t            state_nx_s;
    logic [7:0]        wr_ptr_r;
    logic [7:0]        wr_ptr_nx_s;
    logic [TMO_W-1:0]  tmo_cnt_r;
    logic              tmo_hit_s;
    logic              in_frame_s;

    logic              pend_vld_r;
    logic [ADDR_W-1:0] pend_idx_r;
    logic [7:0]        pend_byte_r;
    logic              pend_set_s;

    logic              wr_en_s;
    logic [ADDR_W-1:0] wr_idx_s;
    logic [7:0]        wr_byte_s;

    logic              done_set_s;
    logic              err_set_s;
    logic [1:0]        err_code_nx_s;
    logic [7:0]        len_nx_s;

`ifdef UART_FRAME_RX_CHECKSUM_EN
    logic [7:0]        csum_r;
    logic [7:0]        csum_nx_s;
`endif

    // Payload storage. Only indices below MAX_LEN are ever written.
    logic [7:0]        pay_mem_r [0:DEPTH-1];

    assign in_frame_s = (state_r == S1_START) || (state_r == S2_PAYLOAD) || (state_r == S3_AMP);
    assign tmo_hit_s  = (tmo_cnt_r == TMO_TC);

    // Next-state, buffer write and frame result decode
    always_comb begin
        state_nx_s    = state_r;
        wr_ptr_nx_s   = wr_ptr_r;
        wr_en_s       = pend_vld_r;
        wr_idx_s      = pend_idx_r;
        wr_byte_s     = pend_byte_r;
        pend_set_s    = 1'b0;
        done_set_s    = 1'b0;
        err_set_s     = 1'b0;
        err_code_nx_s = 2'd0;
        len_nx_s      = 8'd0;
`ifdef UART_FRAME_RX_CHECKSUM_EN
        csum_nx_s     = csum_r;
`endif
        // The pending write above can never meet a new byte: strobes are at
        // least two cycles apart, so the byte path below may override freely.
        case (state_r)
            S0_HUNT: begin
                if (rx_vld && (rx_data == AMP)) begin
                    state_nx_s = S1_START;
                end else begin
                    state_nx_s = S0_HUNT;
                end
            end
            S1_START: begin
                if (rx_vld) begin
                    if (rx_data == AMP) begin
                        state_nx_s  = S2_PAYLOAD;
                        wr_ptr_nx_s = 8'd0;
`ifdef UART_FRAME_RX_CHECKSUM_EN
                        csum_nx_s   = 8'h00;
`endif
                    end else begin
                        state_nx_s = S0_HUNT;
                    end
                end else if (tmo_hit_s) begin
                    state_nx_s = S0_HUNT;
                end else begin
                    state_nx_s = S1_START;
                end
            end
            S2_PAYLOAD: begin
                if (rx_vld) begin
                    if (rx_data == AMP) begin
                        state_nx_s = S3_AMP;
                    end else if ({1'b0, wr_ptr_r} >= MAX_LEN_9) begin
                        state_nx_s    = S0_HUNT;
                        err_set_s     = 1'b1;
                        err_code_nx_s = ERR_OVERFLOW;
                    end else begin
                        wr_en_s     = 1'b1;
                        wr_idx_s    = wr_ptr_r[ADDR_W-1:0];
                        wr_byte_s   = rx_data;
                        wr_ptr_nx_s = wr_ptr_r + 8'd1;
`ifdef UART_FRAME_RX_CHECKSUM_EN
                        csum_nx_s   = csum_r ^ rx_data;
`endif
                    end
                end else if (tmo_hit_s) begin
                    state_nx_s    = S0_HUNT;
                    err_set_s     = 1'b1;
                    err_code_nx_s = ERR_TIMEOUT;
                end else begin
                    state_nx_s = S2_PAYLOAD;
                end
            end
            S3_AMP: begin
                if (rx_vld) begin
                    if (rx_data == AMP) begin
`ifdef UART_FRAME_RX_CHECKSUM_EN
                        // Folding the checksum byte into the running XOR gives zero
                        if ((wr_ptr_r == 8'd0) || (csum_r != 8'h00)) begin
                            state_nx_s    = S0_HUNT;
                            err_set_s     = 1'b1;
                            err_code_nx_s = ERR_CHECKSUM;
                        end else begin
                            state_nx_s = S4_DONE;
                            done_set_s = 1'b1;
                            len_nx_s   = wr_ptr_r - 8'd1;
                        end
`else
                        state_nx_s = S4_DONE;
                        done_set_s = 1'b1;
                        len_nx_s   = wr_ptr_r;
`endif
                    end else if (({1'b0, wr_ptr_r} + 9'd1) >= MAX_LEN_9) begin
                        state_nx_s    = S0_HUNT;
                        err_set_s     = 1'b1;
                        err_code_nx_s = ERR_OVERFLOW;
                    end else begin
                        wr_en_s     = 1'b1;
                        wr_idx_s    = wr_ptr_r[ADDR_W-1:0];
                        wr_byte_s   = AMP;
                        pend_set_s  = 1'b1;
                        wr_ptr_nx_s = wr_ptr_r + 8'd2;
                        state_nx_s  = S2_PAYLOAD;
`ifdef UART_FRAME_RX_CHECKSUM_EN
                        csum_nx_s   = csum_r ^ AMP ^ rx_data;
`endif
                    end
                end else if (tmo_hit_s) begin
                    state_nx_s    = S0_HUNT;
                    err_set_s     = 1'b1;
                    err_code_nx_s = ERR_TIMEOUT;
                end else begin
                    state_nx_s = S3_AMP;
                end
            end
            S4_DONE: begin
                state_nx_s = S0_HUNT;
            end
            default: begin
                state_nx_s = S0_HUNT;
            end
        endcase
    end

    // FSM state, write pointer and pending '&'+X second byte
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r     <= S0_HUNT;
            wr_ptr_r    <= 8'd0;
            pend_vld_r  <= 1'b0;
            pend_idx_r  <= '0;
            pend_byte_r <= 8'h00;
        end else begin
            state_r    <= state_nx_s;
            wr_ptr_r   <= wr_ptr_nx_s;
            pend_vld_r <= pend_set_s;
            if (pend_set_s) begin
                pend_idx_r  <= wr_ptr_r[ADDR_W-1:0] + ADDR_W'(1);
                pend_byte_r <= rx_data;
            end
        end
    end

`ifdef UART_FRAME_RX_CHECKSUM_EN
    // Running XOR of every payload byte written so far
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            csum_r <= 8'h00;
        end else begin
            csum_r <= csum_nx_s;
        end
    end
`endif

    // Inter-byte gap timer: runs only while a frame is being assembled
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            tmo_cnt_r <= '0;
        end else if (rx_vld || tmo_hit_s || !in_frame_s) begin
            tmo_cnt_r <= '0;
        end else begin
            tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
        end
    end

    // Payload buffer write port; contents survive reset on purpose
    always_ff @(posedge sys_clk) begin
        if (wr_en_s) begin
            pay_mem_r[wr_idx_s] <= wr_byte_s;
        end
    end

    // Registered read port, free-running regardless of frame state
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rd_data <= 8'h00;
        end else if (int'(rd_addr) < MAX_LEN) begin
            rd_data <= pay_mem_r[rd_addr];
        end else begin
            rd_data <= 8'h00;
        end
    end

    // Result pulses and held frame status
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            frame_len  <= 8'd0;
            err_code   <= 2'd0;
            busy       <= 1'b0;
        end else begin
            frame_done <= done_set_s;
            frame_err  <= err_set_s;
            busy       <= (state_nx_s != S0_HUNT);
            if (done_set_s) begin
                frame_len <= len_nx_s;
            end
            if (err_set_s) begin
                err_code <= err_code_nx_s;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Testbench for uart_frame_rx. It runs a small clock/timeout configuration
// with MAX_LEN = 8. A byte-stream model in the bench predicts every output
// cycle by cycle. Directed literal expectations per scenario pin that model.
// Define UART_FRAME_RX_CHECKSUM_EN for both files to cover the checksum build.

module tb_uart_frame_rx;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int TIMEOUT_US = 20;
    localparam int MAX_LEN    = 8;
    localparam int ADDR_W     = 3;
    localparam int TC         = CLK_FREQ / 1_000_000 * TIMEOUT_US - 1;
    localparam logic [7:0] AMP = 8'h26;

    logic              sys_clk;
    logic              sys_rst_n;
    logic [7:0]        rx_data;
    logic              rx_vld;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              frame_done;
    logic [7:0]        frame_len;
    logic              frame_err;
    logic [1:0]        err_code;
    logic              busy;

    uart_frame_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .TIMEOUT_US(TIMEOUT_US),
        .MAX_LEN   (MAX_LEN),
        .ADDR_W    (ADDR_W)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .rx_data   (rx_data),
        .rx_vld    (rx_vld),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .frame_done(frame_done),
        .frame_len (frame_len),
        .frame_err (frame_err),
        .err_code  (err_code),
        .busy      (busy)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_done  = 0;
    int n_err   = 0;
    int d0      = 0;
    int e0      = 0;
    logic chk_en = 1'b0;

    // Model state: byte-stream view of the protocol
    logic       m_in_frame;
    logic       m_prev_amp;
    logic       m_pl_valid;
    int         m_since;
    logic [7:0] m_acc [$];
    logic [7:0] m_pl  [$];
    logic       exp_done;
    logic       exp_err;
    logic [7:0] exp_len;
    logic [1:0] exp_code;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 1'b0;
        m_prev_amp = 1'b0;
        m_since    = 0;
        m_acc.delete();
        exp_done   = 1'b0;
        exp_err    = 1'b0;
        exp_len    = 8'd0;
        exp_code   = 2'd0;
    endtask

    // Closing "&&" seen: payload is everything collected before it
    task automatic model_close();
        int plen;
        plen = m_acc.size() - 2;
        m_pl.delete();
        for (int i = 0; i < plen; i++) m_pl.push_back(m_acc[i]);
        m_pl_valid = 1'b1;
`ifdef UART_FRAME_RX_CHECKSUM_EN
        begin
            logic [7:0] x;
            x = 8'h00;
            for (int i = 0; i < plen; i++) x = x ^ m_acc[i];
            if (plen == 0 || x != 8'h00) begin
                exp_err  = 1'b1;
                exp_code = 2'd3;
            end else begin
                exp_done = 1'b1;
                exp_len  = 8'(plen - 1);
            end
        end
`else
        exp_done = 1'b1;
        exp_len  = 8'(plen);
`endif
        m_in_frame = 1'b0;
        m_prev_amp = 1'b0;
    endtask

    task automatic model_byte(input logic [7:0] b);
        int n;
        m_since = 0;
        if (m_in_frame) begin
            m_acc.push_back(b);
            n = m_acc.size();
            if (n >= 2 && m_acc[n-1] == AMP && m_acc[n-2] == AMP) begin
                model_close();
            end else if (b != AMP && n > MAX_LEN) begin
                // the data byte (or second byte of an '&' pair) lands at index n-1
                exp_err    = 1'b1;
                exp_code   = 2'd2;
                m_in_frame = 1'b0;
            end
        end else if (b == AMP) begin
            if (m_prev_amp) begin
                m_in_frame = 1'b1;
                m_prev_amp = 1'b0;
                m_pl_valid = 1'b0;
                m_acc.delete();
            end else begin
                m_prev_amp = 1'b1;
            end
        end else begin
            m_prev_amp = 1'b0;
        end
    endtask

    task automatic model_idle();
        m_since++;
        if (m_since == TC + 1 && (m_in_frame || m_prev_amp)) begin
            if (m_in_frame) begin
                exp_err  = 1'b1;
                exp_code = 2'd1;
            end
            m_in_frame = 1'b0;
            m_prev_amp = 1'b0;
        end
    endtask

    // One clock: the model consumes what the DUT samples at this edge
    task automatic step();
        @(posedge sys_clk);
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (rx_vld) model_byte(rx_data);
        else model_idle();
        #1;
        rx_vld = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_data = b;
        rx_vld  = 1'b1;
        step();
        idle(gap);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i], 2);
    endtask

    task automatic rd_check(input int addr, input logic [7:0] exp, input string name);
        rd_addr = ADDR_W'(addr);
        step();
        chk(name, 32'(rd_data), 32'(exp));
    endtask

    task automatic check_buf();
        if (m_pl_valid) begin
            for (int i = 0; i < m_pl.size(); i++) rd_check(i, m_pl[i], "rd_model");
        end
    endtask

    task automatic expect_res(input string name, input int dd, input int de,
                              input int len, input int code);
        chk({name, "_done_cnt"}, 32'(n_done - d0), 32'(dd));
        chk({name, "_err_cnt"},  32'(n_err - e0),  32'(de));
        chk({name, "_len"},      32'(frame_len),   32'(len));
        chk({name, "_code"},     32'(err_code),    32'(code));
        d0 = n_done;
        e0 = n_err;
    endtask

    // Per-cycle comparison against the model
    always @(negedge sys_clk) begin
        if (chk_en) begin
            chk("frame_done", 32'(frame_done), 32'(exp_done));
            chk("frame_err",  32'(frame_err),  32'(exp_err));
            chk("frame_len",  32'(frame_len),  32'(exp_len));
            chk("err_code",   32'(err_code),   32'(exp_code));
            chk("busy",       32'(busy),       32'(m_in_frame | m_prev_amp | exp_done));
            if (frame_done) n_done++;
            if (frame_err) n_err++;
        end
    end

    initial begin
        sys_rst_n  = 1'b0;
        rx_vld     = 1'b0;
        rx_data    = 8'h00;
        rd_addr    = '0;
        m_pl_valid = 1'b0;
        model_reset();
        idle(3);
        @(negedge sys_clk);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err",  32'(frame_err),  32'd0);
        chk("rst_len",  32'(frame_len),  32'd0);
        chk("rst_code", 32'(err_code),   32'd0);
        chk("rst_busy", 32'(busy),       32'd0);
        chk("rst_rd",   32'(rd_data),    32'd0);
        @(posedge sys_clk);
        #1;
        sys_rst_n = 1'b1;
        chk_en    = 1'b1;
        d0 = n_done;
        e0 = n_err;

        // basic frame
        send_str("&&AB&&"); idle(3);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t1", 0, 1, 0, 3);
`else
        expect_res("t1", 1, 0, 2, 0);
`endif
        rd_check(0, 8'h41, "t1_rd0");
        rd_check(1, 8'h42, "t1_rd1");
        check_buf();

        // leading garbage and a lone '&' as data
        send_str("xy&&A&B&&"); idle(3);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t2", 0, 1, 0, 3);
`else
        expect_res("t2", 1, 0, 3, 0);
`endif
        rd_check(1, 8'h26, "t2_rd1");
        rd_check(2, 8'h42, "t2_rd2");
        check_buf();

        // empty frame
        send_str("&&&&"); idle(3);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t3", 0, 1, 0, 3);
`else
        expect_res("t3", 1, 0, 0, 0);
`endif

        // payload timeout, then recovery
        send_str("&&A"); idle(TC + 2);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t4a", 0, 1, 0, 1);
        send_str("&&C&&"); idle(3);
        expect_res("t4b", 0, 1, 0, 3);
`else
        expect_res("t4a", 0, 1, 0, 1);
        send_str("&&C&&"); idle(3);
        expect_res("t4b", 1, 0, 1, 1);
`endif
        check_buf();

        // byte arriving on the terminal count wins over the timeout
        send_byte(AMP, 2); send_byte(AMP, 2); send_byte(8'h41, TC);
        send_str("B&&"); idle(3);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t5", 0, 1, 0, 3);
`else
        expect_res("t5", 1, 0, 2, 1);
`endif

        // overflow: MAX_LEN+1 data bytes
        send_str("&&abcdefghi"); idle(3);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t6", 0, 1, 0, 2);
`else
        expect_res("t6", 0, 1, 2, 2);
`endif

        // exactly MAX_LEN bytes; the last is the XOR of the first seven
        send_str("&&abcdefg"); send_byte(8'h60, 2); send_str("&&"); idle(3);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t7", 1, 0, 7, 2);
`else
        expect_res("t7", 1, 0, 8, 2);
`endif
        rd_check(7, 8'h60, "t7_rd7");
        check_buf();

        // '&'+X pair whose second write would hit index MAX_LEN
        send_str("&&abcdefg&Z"); idle(3);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t8", 0, 1, 7, 2);
`else
        expect_res("t8", 0, 1, 8, 2);
`endif

        // checksum frames: good and bad
        send_str("&&AB"); send_byte(8'h03, 2); send_str("&&"); idle(3);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t9a", 1, 0, 2, 2);
`else
        expect_res("t9a", 1, 0, 3, 2);
`endif
        check_buf();
        send_str("&&AB"); send_byte(8'h04, 2); send_str("&&"); idle(3);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t9b", 0, 1, 2, 3);
`else
        expect_res("t9b", 1, 0, 3, 2);
`endif

        // single '&' times out silently, then a good frame
        send_byte(AMP, TC + 3);
        send_str("&&QQ&&"); idle(3);
`ifdef UART_FRAME_RX_CHECKSUM_EN
        expect_res("t10", 1, 0, 1, 3);
`else
        expect_res("t10", 1, 0, 2, 2);
`endif

        // reset in the middle of a payload
        send_str("&&AB");
        sys_rst_n = 1'b0;
        model_reset();
        m_pl_valid = 1'b0;
        #1;
        chk("t11_busy", 32'(busy),       32'd0);
        chk("t11_done", 32'(frame_done), 32'd0);
        chk("t11_err",  32'(frame_err),  32'd0);
        idle(2);
        sys_rst_n = 1'b1;
        idle(TC + 5);
        expect_res("t11", 0, 0, 0, 0);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_frame_rx.md
Name: uart_frame_rx

Overview:
- Receive-side frame decoder for the UART "&&payload&&" string protocol.
- Consumes the byte stream from the uart_rx byte receiver (rx_data / rx_vld) and hunts for the "&&" start delimiter.
- Collects payload bytes into an internal buffer until the closing "&&", then flags the frame.
- Exposes the buffer through a registered read port so a command parser can read it after frame_done.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz.
- TIMEOUT_US, 1000, maximum inter-byte gap inside a frame, in microseconds.
- MAX_LEN, 64, payload buffer depth in bytes (1..255).
- ADDR_W, 6, read address width; must satisfy 2^ADDR_W >= MAX_LEN.

Ports:
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset: sys_rst_n, asynchronous, active-low; clock sys_clk.
- rx_data  in  8  received byte; valid only when rx_vld=1.
- rx_vld  in  1  single-cycle strobe per received byte; consecutive strobes are at least 2 cycles apart.
- rd_addr  in  ADDR_W  payload read address.
- rd_data  out  8  payload byte at rd_addr; registered, 1-cycle latency.
- frame_done  out  1  1-cycle pulse when a complete, valid frame has been captured.
- frame_len  out  8  payload length of the last good frame; held until the next frame_done.
- frame_err  out  1  1-cycle pulse on frame abort.
- err_code  out  2  abort cause: 1 = timeout, 2 = overflow, 3 = checksum; held until the next frame_err.
- busy  out  1  high in every state other than S0_HUNT.

Behaviour:
- Reset values: all outputs 0; state S0_HUNT; counters and buffer write pointer 0.
- Buffer contents are not reset.
- States:
  - S0_HUNT: rx_vld with '&' -> S1_START; any other byte is ignored.
  - S1_START: '&' -> S2_PAYLOAD with wr_ptr=0. Other byte -> S0_HUNT, no error. Timeout -> S0_HUNT, no error.
  - S2_PAYLOAD: '&' -> S3_AMP, nothing written. Other byte -> buf[wr_ptr] <= byte, wr_ptr+1.
  - S3_AMP: '&' -> S4_DONE (closing delimiter). Other byte X -> write '&' at wr_ptr this cycle, write X at wr_ptr+1 next cycle (pending register), wr_ptr += 2, return to S2_PAYLOAD.
  - S4_DONE: frame_len <= wr_ptr; frame_done pulses for 1 cycle; -> S0_HUNT.
- Latency: frame_done asserts exactly 1 cycle after the rx_vld that carries the closing '&'.
- A lone '&' inside the payload is data. "&&" cannot appear inside a payload.
- "&&&&" is a valid empty frame: frame_done=1, frame_len=0.
- Overflow: any write that would reach index MAX_LEN (including the second write of an '&'+X pair) -> frame_err, err_code=2, -> S0_HUNT, nothing else written.
- Timeout counter:
  - TIMEOUT_CLK = CLK_FREQ/1_000_000*TIMEOUT_US - 1.
  - Counts only in S1–S3, is cleared on rx_vld and is 0 in S0/S4.
  - Terminal count in S2/S3 -> frame_err, err_code=1, -> S0_HUNT.
  - rx_vld in the same cycle as terminal count: the byte wins and the counter clears.
- frame_done and frame_err never assert in the same cycle.
- A new frame overwrites the buffer from index 0 as soon as payload bytes arrive. Readers must finish before the next frame's first payload byte.
- rd_data <= buf[rd_addr] every cycle, independent of state.
- Reset mid-frame returns to S0_HUNT with no pulse. A partial frame is never reported.

Optional Feature:
- Macro: UART_FRAME_RX_CHECKSUM_EN.
- Defined:
  - The last payload byte is the XOR of all preceding payload bytes. It is stripped and frame_len excludes it.
  - Mismatch, or an empty payload -> frame_err, err_code=3, no frame_done.
  - The running XOR is reset on S1->S2.
- Undefined: no checksum logic; every payload byte is data and err_code=3 never occurs.

Test Plan:
- Bytes "&&AB&&" -> frame_done once, frame_len=2; reads of addr 0,1 -> 0x41, 0x42.
- "xy&&A&B&&" -> frame_len=3, buf = 'A','&','B'; leading garbage ignored, no frame_err.
- "&&&&" -> frame_done, frame_len=0.
- "&&A", then silence of TIMEOUT_CLK+2 cycles -> frame_err, err_code=1. A following "&&C&&" -> frame_len=1.
- MAX_LEN+1 data bytes after "&&" -> frame_err, err_code=2, no frame_done. Exactly MAX_LEN bytes + "&&" -> frame_len=MAX_LEN.
- With UART_FRAME_RX_CHECKSUM_EN: "&&AB\x03&&" -> frame_len=2. "&&AB\x04&&" -> frame_err, err_code=3. Reset asserted mid-payload -> no pulses, busy=0.
